vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 142 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a pixel-clock divider, sync/DE generation
// and four built-in test patterns. Outputs lag the raster counters by one pixel.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_DIV  = 2,
  parameter int   COLOR_W  = 4,
  parameter int   CNT_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     line_col,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [3*COLOR_W-1:0] vga_o,
  output logic [CNT_W-1:0]     pix_x,
  output logic [CNT_W-1:0]     pix_y,
  output logic                 sof,
  output logic [7:0]           frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_ACTIVE / 8);
  localparam logic [3:0]       DIV_LAST = 4'(PIX_DIV - 1);

  logic [3:0]           r_div;
  logic [CNT_W-1:0]     r_hcnt, r_vcnt, r_line_col_q, r_pix_x, r_pix_y;
  logic [1:0]           r_mode_q;
  logic [7:0]           r_frame_cnt;
  logic                 r_sof, r_hs, r_vs, r_de;
  logic [3*COLOR_W-1:0] r_rgb;

  logic                 w_pe, w_h_last, w_v_last, w_frame_end, w_de;
  logic [2:0]           w_bar;
  logic [COLOR_W-1:0]   w_flat;
  logic [3*COLOR_W-1:0] w_rgb;

  assign w_pe        = (r_div == DIV_LAST);
  assign w_h_last    = (r_hcnt == H_LAST);
  assign w_v_last    = (r_vcnt == V_LAST);
  assign w_frame_end = w_pe & w_h_last & w_v_last;
  assign w_de        = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_bar       = 3'(r_hcnt / BAR_W);

  generate
    if (COLOR_W <= 8) begin : g_flat_narrow
      assign w_flat = r_frame_cnt[7 -: COLOR_W];
    end else begin : g_flat_wide
      assign w_flat = {{(COLOR_W-8){1'b0}}, r_frame_cnt};
    end
  endgenerate

  always_comb begin
    w_rgb = '0;
    case (r_mode_q)
      2'd0: if (r_hcnt == r_line_col_q && r_line_col_q < H_ACT)
              w_rgb = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
      2'd1: w_rgb = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      2'd2: if (r_hcnt[4:0] == 5'd0 || r_vcnt[4:0] == 5'd0) w_rgb = '1;
      default: w_rgb = {3{w_flat}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else        r_div <= w_pe ? '0 : r_div + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pe) begin
      r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
      if (w_h_last) r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
    end
  end

  // Pattern controls only change at the frame boundary so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sof        <= 1'b0;
      r_mode_q     <= '0;
      r_line_col_q <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_sof <= w_frame_end;
      if (w_frame_end) begin
        r_mode_q     <= mode;
        r_line_col_q <= line_col;
        r_frame_cnt  <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else if (w_pe) begin
      r_hs  <= (r_hcnt >= HS_BEG && r_hcnt < HS_END) ? HS_POL : ~HS_POL;
      r_vs  <= (r_vcnt >= VS_BEG && r_vcnt < VS_END) ? VS_POL : ~VS_POL;
      r_de  <= w_de;
      r_rgb <= w_de ? w_rgb : '0;
      if (w_de) begin
        r_pix_x <= r_hcnt;
        r_pix_y <= r_vcnt;
      end
    end
  end

  assign vga_hs    = r_hs;
  assign vga_vs    = r_vs;
  assign vga_de    = r_de;
  assign vga_o     = r_rgb;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign sof       = r_sof;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small raster (56x40, PIX_DIV=2) walked through all four
// patterns, plus a tiny PIX_DIV=1 positive-hsync raster run for 256 frames.
module tb_vga_timing_gen;
  localparam int HT  = 56;
  localparam int FR  = 56 * 40;
  localparam int FR2 = 12 * 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst2_n;
  logic [1:0]  mode, mode2;
  logic [11:0] line_col, line_col2;
  logic        hs, vs, de, sof, hs2, vs2, de2, sof2;
  logic [11:0] rgb, px, py, rgb2, px2, py2;
  logic [7:0]  fc, fc2;

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(34), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(2), .COLOR_W(4), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .line_col(line_col),
    .vga_hs(hs), .vga_vs(vs), .vga_de(de), .vga_o(rgb),
    .pix_x(px), .pix_y(py), .sof(sof), .frame_cnt(fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(1), .COLOR_W(4), .CNT_W(12)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .mode(mode2), .line_col(line_col2),
    .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2), .vga_o(rgb2),
    .pix_x(px2), .pix_y(py2), .sof(sof2), .frame_cnt(fc2)
  );

  // Bench-side clock-edge counters since reset release: pixel p of the raster
  // is on the outputs after edge PIX_DIV*(p+1).
  int edges, edges2, sof2_cnt;
  int sofq[$];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0; else edges <= edges + 1;
  always @(posedge clk or negedge rst2_n)
    if (!rst2_n) edges2 <= 0; else edges2 <= edges2 + 1;
  always @(negedge clk) if (sof) sofq.push_back(edges);
  always @(negedge clk or negedge rst2_n)
    if (!rst2_n) sof2_cnt <= 0; else if (sof2) sof2_cnt <= sof2_cnt + 1;

  int passed = 0, total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic wait_edge(input bit second, input int target);
    int guard = 0;
    while ((second ? edges2 : edges) < target && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    if ((second ? edges2 : edges) != target) begin
      total++;
      $display("FAIL timing: edge count %0d expected %0d", second ? edges2 : edges, target);
    end
  endtask

  typedef struct {
    int f, x, y;
    logic [1:0] m;
    int lc;
    logic [11:0] rgb;
    logic de, hs, vs;
    int px, py;
  } vec_t;
  vec_t vq[$];

  initial begin
    // frame 0: mode_q/line_col_q still at reset values (marker at column 0)
    vq.push_back('{0,  0,  0, 2'd0,  7, 12'hF00, 1'b1, 1'b1, 1'b1,  0,  0});
    vq.push_back('{0,  1,  0, 2'd0,  7, 12'h000, 1'b1, 1'b1, 1'b1,  1,  0});
    vq.push_back('{0, 43,  0, 2'd0,  7, 12'h000, 1'b0, 1'b1, 1'b1, 39,  0});
    vq.push_back('{0, 44,  0, 2'd0,  7, 12'h000, 1'b0, 1'b0, 1'b1, 39,  0});
    vq.push_back('{0, 49,  0, 2'd0,  7, 12'h000, 1'b0, 1'b0, 1'b1, 39,  0});
    vq.push_back('{0, 50,  0, 2'd0,  7, 12'h000, 1'b0, 1'b1, 1'b1, 39,  0});
    vq.push_back('{0,  0,  5, 2'd0,  7, 12'hF00, 1'b1, 1'b1, 1'b1,  0,  5});
    vq.push_back('{0,  7,  5, 2'd0,  7, 12'h000, 1'b1, 1'b1, 1'b1,  7,  5});
    vq.push_back('{0,  0, 35, 2'd0,  7, 12'h000, 1'b0, 1'b1, 1'b1, 39, 33});
    vq.push_back('{0,  0, 36, 2'd0,  7, 12'h000, 1'b0, 1'b1, 1'b0, 39, 33});
    vq.push_back('{0, 45, 37, 2'd0,  7, 12'h000, 1'b0, 1'b0, 1'b0, 39, 33});
    vq.push_back('{0,  0, 38, 2'd0,  7, 12'h000, 1'b0, 1'b1, 1'b1, 39, 33});
    // frame 1: marker at column 7; mode switched to grid mid-frame
    vq.push_back('{1,  6,  3, 2'd0,  7, 12'h000, 1'b1, 1'b1, 1'b1,  6,  3});
    vq.push_back('{1,  7,  3, 2'd0,  7, 12'hF00, 1'b1, 1'b1, 1'b1,  7,  3});
    vq.push_back('{1,  8,  3, 2'd0,  7, 12'h000, 1'b1, 1'b1, 1'b1,  8,  3});
    vq.push_back('{1,  7, 20, 2'd2,  7, 12'hF00, 1'b1, 1'b1, 1'b1,  7, 20});
    vq.push_back('{1,  7, 33, 2'd2,  7, 12'hF00, 1'b1, 1'b1, 1'b1,  7, 33});
    // frame 2: grid
    vq.push_back('{2,  0,  0, 2'd2,  7, 12'hFFF, 1'b1, 1'b1, 1'b1,  0,  0});
    vq.push_back('{2,  5,  0, 2'd2,  7, 12'hFFF, 1'b1, 1'b1, 1'b1,  5,  0});
    vq.push_back('{2,  5,  5, 2'd2,  7, 12'h000, 1'b1, 1'b1, 1'b1,  5,  5});
    vq.push_back('{2,  7,  5, 2'd2,  7, 12'h000, 1'b1, 1'b1, 1'b1,  7,  5});
    vq.push_back('{2, 31,  5, 2'd2,  7, 12'h000, 1'b1, 1'b1, 1'b1, 31,  5});
    vq.push_back('{2, 32,  5, 2'd2,  7, 12'hFFF, 1'b1, 1'b1, 1'b1, 32,  5});
    vq.push_back('{2, 33, 31, 2'd2,  7, 12'h000, 1'b1, 1'b1, 1'b1, 33, 31});
    vq.push_back('{2, 33, 32, 2'd1,  7, 12'hFFF, 1'b1, 1'b1, 1'b1, 33, 32});
    // frame 3: colour bars, 5 pixels wide
    vq.push_back('{3,  4,  1, 2'd1,  7, 12'h000, 1'b1, 1'b1, 1'b1,  4,  1});
    vq.push_back('{3,  5,  1, 2'd1,  7, 12'h00F, 1'b1, 1'b1, 1'b1,  5,  1});
    vq.push_back('{3, 10,  1, 2'd1,  7, 12'h0F0, 1'b1, 1'b1, 1'b1, 10,  1});
    vq.push_back('{3, 15,  1, 2'd1,  7, 12'h0FF, 1'b1, 1'b1, 1'b1, 15,  1});
    vq.push_back('{3, 20,  1, 2'd1,  7, 12'hF00, 1'b1, 1'b1, 1'b1, 20,  1});
    vq.push_back('{3, 25,  1, 2'd1,  7, 12'hF0F, 1'b1, 1'b1, 1'b1, 25,  1});
    vq.push_back('{3, 30,  1, 2'd1,  7, 12'hFF0, 1'b1, 1'b1, 1'b1, 30,  1});
    vq.push_back('{3, 39,  1, 2'd1,  7, 12'hFFF, 1'b1, 1'b1, 1'b1, 39,  1});
    vq.push_back('{3, 40,  1, 2'd1,  7, 12'h000, 1'b0, 1'b1, 1'b1, 39,  1});
    vq.push_back('{3, 35, 10, 2'd0, 45, 12'hFFF, 1'b1, 1'b1, 1'b1, 35, 10});
    // frame 4: marker column beyond the active width -> all black
    vq.push_back('{4,  0,  0, 2'd0, 45, 12'h000, 1'b1, 1'b1, 1'b1,  0,  0});
    vq.push_back('{4, 39,  2, 2'd0, 45, 12'h000, 1'b1, 1'b1, 1'b1, 39,  2});

    rst_n = 1'b0; rst2_n = 1'b0;
    mode = 2'd0; line_col = 12'd7; mode2 = 2'd3; line_col2 = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst hs", hs, 1); chk("rst vs", vs, 1); chk("rst de", de, 0);
    chk("rst rgb", rgb, 0); chk("rst px", px, 0); chk("rst py", py, 0);
    chk("rst sof", sof, 0); chk("rst fc", fc, 0);
    chk("rst hs2 (pos pol)", hs2, 0); chk("rst vs2", vs2, 1);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      mode = vq[i].m;
      line_col = 12'(vq[i].lc);
      wait_edge(0, 2 * (vq[i].f * FR + vq[i].y * HT + vq[i].x + 1));
      chk($sformatf("row%0d rgb", i), rgb, vq[i].rgb);
      chk($sformatf("row%0d de", i), de, vq[i].de);
      chk($sformatf("row%0d hs", i), hs, vq[i].hs);
      chk($sformatf("row%0d vs", i), vs, vq[i].vs);
      chk($sformatf("row%0d pix_x", i), px, vq[i].px);
      chk($sformatf("row%0d pix_y", i), py, vq[i].py);
      chk($sformatf("row%0d frame_cnt", i), fc, vq[i].f);
    end

    // one single-clk sof per frame, exactly at each frame boundary
    chk("sof count", sofq.size(), 4);
    for (int k = 0; k < 4 && k < sofq.size(); k++)
      chk($sformatf("sof%0d edge", k), sofq[k], 2 * FR * (k + 1));

    // asynchronous reset mid-frame
    wait_edge(0, 2 * (4 * FR + 10 * HT + 20 + 1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid-rst hs", hs, 1); chk("mid-rst vs", vs, 1); chk("mid-rst de", de, 0);
    chk("mid-rst rgb", rgb, 0); chk("mid-rst px", px, 0); chk("mid-rst py", py, 0);
    chk("mid-rst sof", sof, 0); chk("mid-rst fc", fc, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_edge(0, 1);
    chk("post-rst no pe yet de", de, 0);
    wait_edge(0, 2);
    chk("post-rst (0,0) de", de, 1);
    chk("post-rst (0,0) rgb", rgb, 12'hF00);
    chk("post-rst (0,0) px", px, 0);
    chk("post-rst (0,0) py", py, 0);
    chk("post-rst fc", fc, 0);
    wait_edge(0, 4);
    chk("post-rst (1,0) rgb", rgb, 12'h000);
    chk("post-rst (1,0) px", px, 1);

    // second raster: PIX_DIV=1, positive hsync, 256 frames
    @(negedge clk) rst2_n = 1'b1;
    wait_edge(1, 1);
    chk("d2 (0,0) rgb", rgb2, 12'hF00); chk("d2 (0,0) hs", hs2, 0);
    chk("d2 (0,0) vs", vs2, 1); chk("d2 (0,0) de", de2, 1);
    wait_edge(1, 9);  chk("d2 x8 hs", hs2, 0); chk("d2 x8 de", de2, 0);
    wait_edge(1, 10); chk("d2 x9 hs", hs2, 1);
    wait_edge(1, 11); chk("d2 x10 hs", hs2, 1);
    wait_edge(1, 12); chk("d2 x11 hs", hs2, 0);
    wait_edge(1, 37); chk("d2 row3 vs", vs2, 0);
    wait_edge(1, FR2);     chk("d2 sof1", sof2, 1); chk("d2 fc1", fc2, 1);
    wait_edge(1, FR2 + 1); chk("d2 sof1 width", sof2, 0); chk("d2 f1 flat", rgb2, 12'h000);
    wait_edge(1, 17 * FR2 + 1);  chk("d2 f17 flat", rgb2, 12'h111); chk("d2 fc17", fc2, 17);
    wait_edge(1, 255 * FR2);     chk("d2 fc255", fc2, 255); chk("d2 sof255", sof2, 1);
    wait_edge(1, 255 * FR2 + 1); chk("d2 f255 flat", rgb2, 12'hFFF);
    wait_edge(1, 256 * FR2);     chk("d2 fc wrap", fc2, 0); chk("d2 sof256", sof2, 1);
    wait_edge(1, 256 * FR2 + 1); chk("d2 sof count", sof2_cnt, 256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
